// File: rtl/cq_ptr_alloc_pkg.sv
// Shared pointer arithmetic for flipped-bit circular queues (ROB, LQ, SQ, immBuffer).
// Pointers are carried in a fixed-width generic form so one set of helpers serves every depth.
package cq_ptr_pkg;

  localparam int unsigned PTR_IDX_MAX = 16;

  typedef struct packed {
    logic                   flip;
    logic [PTR_IDX_MAX-1:0] idx;
  } gptr_t;

  // Advance by k slots; crossing the end of a non-power-of-two ring toggles the flip bit.
  function automatic gptr_t ptr_adv(input gptr_t ptr, input int unsigned k,
                                    input int unsigned depth);
    int unsigned s;
    gptr_t       r;
    s = 32'(ptr.idx) + k;
    r = ptr;
    if (s >= depth) begin
      r.idx  = PTR_IDX_MAX'(s - depth);
      r.flip = ~ptr.flip;
    end else begin
      r.idx = PTR_IDX_MAX'(s);
    end
    return r;
  endfunction

  function automatic logic ptr_older(input gptr_t a, input gptr_t b);
    return (a.flip == b.flip) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

  // Signed so a pointer that lies behind head yields a negative distance.
  function automatic int ptr_dist(input gptr_t head, input gptr_t tail,
                                  input int unsigned depth);
    int h;
    int t;
    h = int'(32'(head.idx));
    t = int'(32'(tail.idx));
    if (head.flip == tail.flip) return t - h;
    else                        return int'(depth) - h + t;
  endfunction

endpackage

// File: rtl/cq_ptr_alloc_if.sv
// Request/status bundle between a queue controller and its pointer allocator.
interface cq_ptr_alloc_if #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned ALLOC_WIDTH  = 4,
  parameter int unsigned COMMIT_WIDTH = 4
);
  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned CMW  = $clog2(COMMIT_WIDTH + 1);

  logic [ALLOC_WIDTH-1:0]            i_alloc_vld;
  logic                              o_alloc_rdy;
  logic [ALLOC_WIDTH*(IDXW+1)-1:0]   o_alloc_idx;
  logic [CMW-1:0]                    i_commit_num;
  logic                              i_squash;
  logic [IDXW:0]                     i_squash_idx;
  logic [IDXW:0]                     o_head;
  logic [IDXW:0]                     o_tail;
  logic [CNTW-1:0]                   o_count;
  logic                              o_full;
  logic                              o_empty;
  logic                              o_err;

  modport master (
    output i_alloc_vld, i_commit_num, i_squash, i_squash_idx,
    input  o_alloc_rdy, o_alloc_idx, o_head, o_tail, o_count, o_full, o_empty, o_err
  );

  modport slave (
    input  i_alloc_vld, i_commit_num, i_squash, i_squash_idx,
    output o_alloc_rdy, o_alloc_idx, o_head, o_tail, o_count, o_full, o_empty, o_err
  );
endinterface

// File: rtl/cq_ptr_adv.sv
// Combinational wrap-adder: {flip, idx} + k modulo DEPTH with flip toggle on wrap.
module cq_ptr_adv
  import cq_ptr_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned KW    = 3,
  localparam int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic [IDXW:0] ptr_i,
  input  logic [KW-1:0] k_i,
  output logic [IDXW:0] ptr_o
);
  gptr_t g_in;
  gptr_t g_out;

  always_comb begin
    g_in  = '{flip: ptr_i[IDXW], idx: PTR_IDX_MAX'(ptr_i[IDXW-1:0])};
    g_out = ptr_adv(g_in, 32'(k_i), DEPTH);
    ptr_o = {g_out.flip, IDXW'(g_out.idx)};
  end
endmodule

// File: rtl/cq_ptr_alloc.sv
// Circular-queue head/tail allocator: multi-lane alloc, multi-entry commit, squash rollback.
// Count, full and empty are registered and kept in step with the pointers.
module cq_ptr_alloc
  import cq_ptr_pkg::*;
#(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned ALLOC_WIDTH  = 4,
  parameter int unsigned COMMIT_WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  cq_ptr_alloc_if.slave bus
);
  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned CMW  = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned AKW  = $clog2(ALLOC_WIDTH + 1);

  typedef logic [IDXW:0] ptr_t;

  if (DEPTH < 2 || ALLOC_WIDTH < 1 || COMMIT_WIDTH < 1 || ALLOC_WIDTH > DEPTH ||
      COMMIT_WIDTH > DEPTH || DEPTH > (1 << PTR_IDX_MAX)) begin : g_bad_cfg
    $error("cq_ptr_alloc: illegal DEPTH/ALLOC_WIDTH/COMMIT_WIDTH combination");
  end

  function automatic gptr_t to_g(input ptr_t p);
    return '{flip: p[IDXW], idx: PTR_IDX_MAX'(p[IDXW-1:0])};
  endfunction

  ptr_t            head_q, head_d;
  ptr_t            tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            err_q, err_d;

  logic [AKW-1:0]  lane_off [ALLOC_WIDTH];
  ptr_t            lane_ptr [ALLOC_WIDTH];
  logic [AKW-1:0]  run_cnt;
  logic [AKW-1:0]  alloc_pop;
  logic            alloc_rdy;
  logic            alloc_fire;
  ptr_t            head_adv;
  ptr_t            tail_adv;
  logic            commit_ok;
  logic            squash_ok;
  int unsigned     cnt_after;
  int              sq_dist;

  // Each lane takes the tail offset by the number of valid lanes below it.
  always_comb begin
    run_cnt = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      lane_off[i] = run_cnt;
      run_cnt     = run_cnt + AKW'(bus.i_alloc_vld[i]);
    end
    alloc_pop = run_cnt;
  end

  for (genvar gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_lane
    cq_ptr_adv #(.DEPTH(DEPTH), .KW(AKW)) u_lane_adv (
      .ptr_i (tail_q),
      .k_i   (lane_off[gi]),
      .ptr_o (lane_ptr[gi])
    );
    assign bus.o_alloc_idx[gi*(IDXW+1) +: IDXW+1] = lane_ptr[gi];
  end

  cq_ptr_adv #(.DEPTH(DEPTH), .KW(AKW)) u_tail_adv (
    .ptr_i (tail_q),
    .k_i   (alloc_pop),
    .ptr_o (tail_adv)
  );

  cq_ptr_adv #(.DEPTH(DEPTH), .KW(CMW)) u_head_adv (
    .ptr_i (head_q),
    .k_i   (bus.i_commit_num),
    .ptr_o (head_adv)
  );

  // Ready looks only at the registered count, never at a same-cycle commit.
  assign alloc_rdy  = !bus.i_squash && ((DEPTH - 32'(count_q)) >= 32'(alloc_pop));
  assign alloc_fire = alloc_rdy && (|bus.i_alloc_vld);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    commit_ok = 32'(bus.i_commit_num) <= 32'(count_q);
    head_d    = commit_ok ? head_adv : head_q;
    cnt_after = 32'(count_q) - (commit_ok ? 32'(bus.i_commit_num) : 32'd0);
    sq_dist   = ptr_dist(to_g(head_d), to_g(bus.i_squash_idx), DEPTH);
    squash_ok = (32'(bus.i_squash_idx[IDXW-1:0]) < DEPTH) &&
                (sq_dist >= 0) && (sq_dist <= int'(cnt_after));
    tail_d    = tail_q;
    count_d   = CNTW'(cnt_after);
    err_d     = err_q | !commit_ok;

    if (bus.i_squash) begin
      if (squash_ok) begin
        tail_d  = bus.i_squash_idx;
        count_d = CNTW'(sq_dist);
      end else begin
        err_d = 1'b1;
      end
    end else if (alloc_fire) begin
      tail_d  = tail_adv;
      count_d = CNTW'(cnt_after + 32'(alloc_pop));
    end

    full_d  = (32'(count_d) == DEPTH);
    empty_d = (count_d == '0);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_alloc_rdy = alloc_rdy;
  assign bus.o_head      = head_q;
  assign bus.o_tail      = tail_q;
  assign bus.o_count     = count_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_cq_ptr_alloc.sv
// Directed bench: a DEPTH=60 and a DEPTH=64 allocator driven through fill, wrap, commit and squash.
module tb_cq_ptr_alloc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cq_ptr_alloc_if #(.DEPTH(60), .ALLOC_WIDTH(4), .COMMIT_WIDTH(4)) b60 ();
  cq_ptr_alloc_if #(.DEPTH(64), .ALLOC_WIDTH(4), .COMMIT_WIDTH(4)) b64 ();

  cq_ptr_alloc #(.DEPTH(60), .ALLOC_WIDTH(4), .COMMIT_WIDTH(4)) dut60 (
    .clk (clk), .rst (rst), .bus (b60.slave)
  );
  cq_ptr_alloc #(.DEPTH(64), .ALLOC_WIDTH(4), .COMMIT_WIDTH(4)) dut64 (
    .clk (clk), .rst (rst), .bus (b64.slave)
  );

  function automatic logic [6:0] p(input logic f, input int unsigned i);
    return {f, 6'(i)};
  endfunction

  function automatic logic [22:0] st60();
    return {b60.o_head, b60.o_tail, b60.o_count, b60.o_full, b60.o_empty, b60.o_err};
  endfunction

  function automatic logic [22:0] e60(input logic [6:0] h, input logic [6:0] t,
                                      input int unsigned c, input logic er);
    return {h, t, 6'(c), c == 60, c == 0, er};
  endfunction

  function automatic logic [23:0] st64();
    return {b64.o_head, b64.o_tail, b64.o_count, b64.o_full, b64.o_empty, b64.o_err};
  endfunction

  function automatic logic [23:0] e64(input logic [6:0] h, input logic [6:0] t,
                                      input int unsigned c, input logic er);
    return {h, t, 7'(c), c == 64, c == 0, er};
  endfunction

  task automatic idle();
    b60.i_alloc_vld = '0; b60.i_commit_num = '0; b60.i_squash = 1'b0; b60.i_squash_idx = '0;
    b64.i_alloc_vld = '0; b64.i_commit_num = '0; b64.i_squash = 1'b0; b64.i_squash_idx = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (st60() !== e60(p(0,0), p(0,0), 0, 1'b0)) begin
      failures++; $display("FAIL reset_state60 got=%h exp=%h", st60(), e60(p(0,0), p(0,0), 0, 1'b0));
    end
    checks++; if (st64() !== e64(p(0,0), p(0,0), 0, 1'b0)) begin
      failures++; $display("FAIL reset_state64 got=%h exp=%h", st64(), e64(p(0,0), p(0,0), 0, 1'b0));
    end
    checks++; if (b60.o_alloc_rdy !== 1'b1) begin
      failures++; $display("FAIL reset_rdy got=%b exp=1", b60.o_alloc_rdy);
    end
  endtask

  task automatic test_empty_commit();
    b60.i_commit_num = 3'd0;
    tick();
    checks++; if (st60() !== e60(p(0,0), p(0,0), 0, 1'b0)) begin
      failures++; $display("FAIL empty_commit0 got=%h exp=%h", st60(), e60(p(0,0), p(0,0), 0, 1'b0));
    end
    b60.i_commit_num = 3'd1;
    tick();
    b60.i_commit_num = 3'd0;
    checks++; if (st60() !== e60(p(0,0), p(0,0), 0, 1'b1)) begin
      failures++; $display("FAIL empty_commit1 got=%h exp=%h", st60(), e60(p(0,0), p(0,0), 0, 1'b1));
    end
  endtask

  task automatic test_sparse_lanes();
    b60.i_alloc_vld = 4'b1111;
    tick();
    tick();
    b60.i_alloc_vld = 4'b0011;
    tick();
    b60.i_alloc_vld = 4'b1010;
    #1;
    checks++; if (b60.o_alloc_rdy !== 1'b1) begin
      failures++; $display("FAIL sparse_rdy got=%b exp=1", b60.o_alloc_rdy);
    end
    checks++; if ({b60.o_alloc_idx[27:21], b60.o_alloc_idx[13:7]} !== {p(0,11), p(0,10)}) begin
      failures++; $display("FAIL sparse_lanes got=%h/%h exp=%h/%h", b60.o_alloc_idx[27:21],
                           b60.o_alloc_idx[13:7], p(0,11), p(0,10));
    end
    tick();
    b60.i_alloc_vld = 4'b0000;
    checks++; if (st60() !== e60(p(0,0), p(0,12), 12, 1'b1)) begin
      failures++; $display("FAIL sparse_state got=%h exp=%h", st60(), e60(p(0,0), p(0,12), 12, 1'b1));
    end
  endtask

  task automatic test_reset_mid_burst();
    b60.i_alloc_vld  = 4'b1111;
    b60.i_commit_num = 3'd2;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    b60.i_alloc_vld  = 4'b0000;
    b60.i_commit_num = 3'd0;
    checks++; if (st60() !== e60(p(0,0), p(0,0), 0, 1'b0)) begin
      failures++; $display("FAIL reset_mid_burst got=%h exp=%h", st60(), e60(p(0,0), p(0,0), 0, 1'b0));
    end
  endtask

  task automatic test_fill();
    logic [28:0] exp_v;
    for (int c = 0; c < 15; c++) begin
      b60.i_alloc_vld = 4'b1111;
      #1;
      exp_v = {1'b1, p(0, 4*c+3), p(0, 4*c+2), p(0, 4*c+1), p(0, 4*c)};
      checks++; if ({b60.o_alloc_rdy, b60.o_alloc_idx} !== exp_v) begin
        failures++; $display("FAIL fill_cycle%0d got=%h exp=%h", c,
                             {b60.o_alloc_rdy, b60.o_alloc_idx}, exp_v);
      end
      tick();
    end
    #1;
    checks++; if (b60.o_alloc_rdy !== 1'b0) begin
      failures++; $display("FAIL fill_full_rdy got=%b exp=0", b60.o_alloc_rdy);
    end
    b60.i_alloc_vld = 4'b0000;
    checks++; if (st60() !== e60(p(0,0), p(1,0), 60, 1'b0)) begin
      failures++; $display("FAIL fill_state got=%h exp=%h", st60(), e60(p(0,0), p(1,0), 60, 1'b0));
    end
  endtask

  task automatic test_full_commit();
    b60.i_alloc_vld  = 4'b1111;
    b60.i_commit_num = 3'd3;
    #1;
    checks++; if (b60.o_alloc_rdy !== 1'b0) begin
      failures++; $display("FAIL full_commit_rdy got=%b exp=0", b60.o_alloc_rdy);
    end
    tick();
    b60.i_commit_num = 3'd0;
    checks++; if (st60() !== e60(p(0,3), p(1,0), 57, 1'b0)) begin
      failures++; $display("FAIL full_commit_state got=%h exp=%h", st60(), e60(p(0,3), p(1,0), 57, 1'b0));
    end
    #1;
    checks++; if (b60.o_alloc_rdy !== 1'b0) begin
      failures++; $display("FAIL full_commit_rdy4 got=%b exp=0", b60.o_alloc_rdy);
    end
    b60.i_alloc_vld = 4'b0111;
    #1;
    checks++; if ({b60.o_alloc_rdy, b60.o_alloc_idx[20:0]} !== {1'b1, p(1,2), p(1,1), p(1,0)}) begin
      failures++; $display("FAIL full_commit_lanes got=%h exp=%h", {b60.o_alloc_rdy, b60.o_alloc_idx[20:0]},
                           {1'b1, p(1,2), p(1,1), p(1,0)});
    end
    tick();
    b60.i_alloc_vld = 4'b0000;
    checks++; if (st60() !== e60(p(0,3), p(1,3), 60, 1'b0)) begin
      failures++; $display("FAIL refill_state got=%h exp=%h", st60(), e60(p(0,3), p(1,3), 60, 1'b0));
    end
  endtask

  task automatic test_wrap60();
    b60.i_commit_num = 3'd4;
    tick();
    b60.i_alloc_vld = 4'b1111;
    repeat (13) tick();
    b60.i_alloc_vld = 4'b0011;
    tick();
    b60.i_alloc_vld  = 4'b0000;
    b60.i_commit_num = 3'd0;
    checks++; if (st60() !== e60(p(1,3), p(1,57), 54, 1'b0)) begin
      failures++; $display("FAIL wrap60_pre got=%h exp=%h", st60(), e60(p(1,3), p(1,57), 54, 1'b0));
    end
    b60.i_alloc_vld = 4'b1111;
    #1;
    checks++; if ({b60.o_alloc_rdy, b60.o_alloc_idx} !== {1'b1, p(0,0), p(1,59), p(1,58), p(1,57)}) begin
      failures++; $display("FAIL wrap60_lanes got=%h exp=%h", {b60.o_alloc_rdy, b60.o_alloc_idx},
                           {1'b1, p(0,0), p(1,59), p(1,58), p(1,57)});
    end
    tick();
    b60.i_alloc_vld = 4'b0000;
    checks++; if (st60() !== e60(p(1,3), p(0,1), 58, 1'b0)) begin
      failures++; $display("FAIL wrap60_post got=%h exp=%h", st60(), e60(p(1,3), p(0,1), 58, 1'b0));
    end
    b60.i_alloc_vld = 4'b0111;
    #1;
    checks++; if (b60.o_alloc_rdy !== 1'b0) begin
      failures++; $display("FAIL wrap60_rdy3 got=%b exp=0", b60.o_alloc_rdy);
    end
    b60.i_alloc_vld = 4'b0110;
    #1;
    checks++; if ({b60.o_alloc_rdy, b60.o_alloc_idx[20:7]} !== {1'b1, p(0,2), p(0,1)}) begin
      failures++; $display("FAIL wrap60_last2 got=%h exp=%h", {b60.o_alloc_rdy, b60.o_alloc_idx[20:7]},
                           {1'b1, p(0,2), p(0,1)});
    end
    tick();
    b60.i_alloc_vld = 4'b0000;
    checks++; if (st60() !== e60(p(1,3), p(0,3), 60, 1'b0)) begin
      failures++; $display("FAIL wrap60_full got=%h exp=%h", st60(), e60(p(1,3), p(0,3), 60, 1'b0));
    end
  endtask

  task automatic test_setup64();
    b64.i_alloc_vld = 4'b1111;
    repeat (11) tick();
    b64.i_commit_num = 3'd4;
    repeat (6) tick();
    b64.i_alloc_vld = 4'b0001;
    tick();
    b64.i_alloc_vld = 4'b0000;
    repeat (3) tick();
    b64.i_commit_num = 3'd0;
    checks++; if (st64() !== e64(p(0,40), p(1,5), 29, 1'b0)) begin
      failures++; $display("FAIL setup64 got=%h exp=%h", st64(), e64(p(0,40), p(1,5), 29, 1'b0));
    end
  endtask

  task automatic test_squash_err();
    b64.i_squash     = 1'b1;
    b64.i_squash_idx = p(0,30);
    b64.i_alloc_vld  = 4'b1111;
    #1;
    checks++; if (b64.o_alloc_rdy !== 1'b0) begin
      failures++; $display("FAIL squash_err_rdy got=%b exp=0", b64.o_alloc_rdy);
    end
    tick();
    idle();
    checks++; if (st64() !== e64(p(0,40), p(1,5), 29, 1'b1)) begin
      failures++; $display("FAIL squash_err_state got=%h exp=%h", st64(), e64(p(0,40), p(1,5), 29, 1'b1));
    end
  endtask

  task automatic test_squash_commit();
    b64.i_squash     = 1'b1;
    b64.i_squash_idx = p(0,50);
    b64.i_commit_num = 3'd2;
    b64.i_alloc_vld  = 4'b1111;
    #1;
    checks++; if (b64.o_alloc_rdy !== 1'b0) begin
      failures++; $display("FAIL squash_commit_rdy got=%b exp=0", b64.o_alloc_rdy);
    end
    tick();
    idle();
    checks++; if (st64() !== e64(p(0,42), p(0,50), 8, 1'b1)) begin
      failures++; $display("FAIL squash_commit_state got=%h exp=%h", st64(), e64(p(0,42), p(0,50), 8, 1'b1));
    end
  endtask

  task automatic test_commit_err_and_range();
    b64.i_commit_num = 3'd5;
    tick();
    checks++; if (st64() !== e64(p(0,47), p(0,50), 3, 1'b1)) begin
      failures++; $display("FAIL commit5_state got=%h exp=%h", st64(), e64(p(0,47), p(0,50), 3, 1'b1));
    end
    tick();
    b64.i_commit_num = 3'd0;
    checks++; if (st64() !== e64(p(0,47), p(0,50), 3, 1'b1)) begin
      failures++; $display("FAIL commit_over_count got=%h exp=%h", st64(), e64(p(0,47), p(0,50), 3, 1'b1));
    end
    b64.i_squash     = 1'b1;
    b64.i_squash_idx = p(0,52);
    tick();
    checks++; if (st64() !== e64(p(0,47), p(0,50), 3, 1'b1)) begin
      failures++; $display("FAIL squash_past_tail got=%h exp=%h", st64(), e64(p(0,47), p(0,50), 3, 1'b1));
    end
    b64.i_squash_idx = p(0,47);
    tick();
    idle();
    checks++; if (st64() !== e64(p(0,47), p(0,47), 0, 1'b1)) begin
      failures++; $display("FAIL squash_to_head got=%h exp=%h", st64(), e64(p(0,47), p(0,47), 0, 1'b1));
    end
  endtask

  task automatic test_wrap64();
    b64.i_alloc_vld = 4'b1111;
    repeat (3) tick();
    b64.i_alloc_vld = 4'b0111;
    tick();
    b64.i_alloc_vld = 4'b1111;
    #1;
    checks++; if ({b64.o_alloc_rdy, b64.o_alloc_idx} !== {1'b1, p(1,1), p(1,0), p(0,63), p(0,62)}) begin
      failures++; $display("FAIL wrap64_lanes got=%h exp=%h", {b64.o_alloc_rdy, b64.o_alloc_idx},
                           {1'b1, p(1,1), p(1,0), p(0,63), p(0,62)});
    end
    tick();
    idle();
    checks++; if (st64() !== e64(p(0,47), p(1,2), 19, 1'b1)) begin
      failures++; $display("FAIL wrap64_state got=%h exp=%h", st64(), e64(p(0,47), p(1,2), 19, 1'b1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_empty_commit();
    test_sparse_lanes();
    test_reset_mid_burst();
    test_fill();
    test_full_commit();
    test_wrap60();
    test_setup64();
    test_squash_err();
    test_squash_commit();
    test_commit_err_and_range();
    test_wrap64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
